// File: rtl/phys_reg_file_bypass.sv
// Physical register file with per-register ready table, same-cycle write-to-read bypass,
// hardwired-zero p0 and a registered multi-write conflict flag.
module phys_reg_file_bypass #(
   parameter int unsigned NUM_P_REGS = 64,
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned NUM_WR     = 2,
   parameter int unsigned NUM_RD     = 4,
   parameter int unsigned NUM_ALLOC  = 2,
   localparam int unsigned AW        = (NUM_P_REGS > 1) ? $clog2(NUM_P_REGS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_WR-1:0]             we_i,
   input  logic [NUM_WR*AW-1:0]          wdest_i,
   input  logic [NUM_WR*WORD_SIZE-1:0]   wdata_i,
   input  logic [NUM_RD*AW-1:0]          raddr_i,
   output logic [NUM_RD*WORD_SIZE-1:0]   rdata_o,
   output logic [NUM_RD-1:0]             rready_o,
   input  logic [NUM_ALLOC-1:0]          alloc_en_i,
   input  logic [NUM_ALLOC*AW-1:0]       alloc_preg_i,
   output logic                          wr_conflict_o
);

   logic [WORD_SIZE-1:0]  rf_q [NUM_P_REGS];
   logic [WORD_SIZE-1:0]  rf_d [NUM_P_REGS];
   logic [NUM_P_REGS-1:0] ready_q, ready_d;
   logic                  conflict_q, conflict_d;

   // p0 and addresses beyond the last register are never stored or cleared.
   function automatic logic addr_ok(logic [AW-1:0] a);
      return (a != '0) && (32'(a) < NUM_P_REGS);
   endfunction

   always_comb begin
      rf_d       = rf_q;
      ready_d    = ready_q;
      conflict_d = 1'b0;
      // Ascending port order lets the highest-index writer win.
      for (int k = 0; k < NUM_WR; k++) begin
         if (we_i[k] && addr_ok(wdest_i[k*AW +: AW])) begin
            rf_d[wdest_i[k*AW +: AW]]    = wdata_i[k*WORD_SIZE +: WORD_SIZE];
            ready_d[wdest_i[k*AW +: AW]] = 1'b1;
            for (int j = k + 1; j < NUM_WR; j++) begin
               if (we_i[j] && (wdest_i[j*AW +: AW] == wdest_i[k*AW +: AW])) begin
                  conflict_d = 1'b1;
               end
            end
         end
      end
      // Allocation is applied last so it overrides a same-cycle write's ready bit.
      for (int a = 0; a < NUM_ALLOC; a++) begin
         if (alloc_en_i[a] && addr_ok(alloc_preg_i[a*AW +: AW])) begin
            ready_d[alloc_preg_i[a*AW +: AW]] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_P_REGS; i++) begin
            rf_q[i] <= '0;
         end
         ready_q    <= '1;
         conflict_q <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         ready_q    <= ready_d;
         conflict_q <= conflict_d;
      end
   end

   always_comb begin
      rdata_o  = '0;
      rready_o = '1;
      for (int r = 0; r < NUM_RD; r++) begin
         if (addr_ok(raddr_i[r*AW +: AW])) begin
            rdata_o[r*WORD_SIZE +: WORD_SIZE] = rf_q[raddr_i[r*AW +: AW]];
            rready_o[r]                       = ready_q[raddr_i[r*AW +: AW]];
            // Bypass is suppressed while reset holds the file at zero.
            if (!rst_i) begin
               for (int k = 0; k < NUM_WR; k++) begin
                  if (we_i[k] && (wdest_i[k*AW +: AW] == raddr_i[r*AW +: AW])) begin
                     rdata_o[r*WORD_SIZE +: WORD_SIZE] = wdata_i[k*WORD_SIZE +: WORD_SIZE];
                     rready_o[r]                       = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_phys_reg_file_bypass.sv
// Randomised and directed bench for phys_reg_file_bypass against a behavioural array model.
module tb_phys_reg_file_bypass;

   localparam int NP = 48;
   localparam int WS = 32;
   localparam int NW = 2;
   localparam int NR = 4;
   localparam int NA = 2;
   localparam int AW = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NW-1:0]        we;
   logic [NW*AW-1:0]     wdest;
   logic [NW*WS-1:0]     wdata;
   logic [NR*AW-1:0]     raddr;
   logic [NR*WS-1:0]     rdata;
   logic [NR-1:0]        rready;
   logic [NA-1:0]        alloc_en;
   logic [NA*AW-1:0]     alloc_preg;
   logic                 wr_conflict;

   int checks   = 0;
   int failures = 0;

   logic [WS-1:0] m_rf  [64];
   logic          m_rdy [64];
   logic          m_conf;

   phys_reg_file_bypass #(
      .NUM_P_REGS(NP),
      .WORD_SIZE (WS),
      .NUM_WR    (NW),
      .NUM_RD    (NR),
      .NUM_ALLOC (NA)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .we_i         (we),
      .wdest_i      (wdest),
      .wdata_i      (wdata),
      .raddr_i      (raddr),
      .rdata_o      (rdata),
      .rready_o     (rready),
      .alloc_en_i   (alloc_en),
      .alloc_preg_i (alloc_preg),
      .wr_conflict_o(wr_conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit valid(input int a);
      return (a != 0) && (a < NP);
   endfunction

   function automatic int wd(input int k);
      return int'(wdest[k*AW +: AW]);
   endfunction

   // Any two enabled writers on the same storable register.
   function automatic logic conflict_now();
      for (int i = 0; i < NW; i++)
         for (int j = i + 1; j < NW; j++)
            if (we[i] && we[j] && valid(wd(i)) && wd(i) == wd(j)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            m_rf[i]  <= '0;
            m_rdy[i] <= 1'b1;
         end
         m_conf <= 1'b0;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (we[k] && valid(wd(k))) begin
               m_rf[wd(k)]  <= wdata[k*WS +: WS];
               m_rdy[wd(k)] <= 1'b1;
            end
         end
         for (int a = 0; a < NA; a++) begin
            if (alloc_en[a] && valid(int'(alloc_preg[a*AW +: AW])))
               m_rdy[int'(alloc_preg[a*AW +: AW])] <= 1'b0;
         end
         m_conf <= conflict_now();
      end
   end

   // Compare process: every negedge, all read ports plus the conflict flag.
   always @(negedge clk) begin
      for (int r = 0; r < NR; r++) begin
         int            a;
         logic [WS-1:0] ed;
         logic          er;
         a  = int'(raddr[r*AW +: AW]);
         ed = '0;
         er = 1'b1;
         if (!rst && valid(a)) begin
            ed = m_rf[a];
            er = m_rdy[a];
            for (int k = 0; k < NW; k++) begin
               if (we[k] && wd(k) == a) begin
                  ed = wdata[k*WS +: WS];
                  er = 1'b1;
               end
            end
         end
         chk($sformatf("model_rdata%0d", r), rdata[r*WS +: WS], ed);
         chk($sformatf("model_rready%0d", r), {31'd0, rready[r]}, {31'd0, er});
      end
      chk("model_conflict", {31'd0, wr_conflict}, {31'd0, m_conf});
   end

   task automatic idle();
      we = '0; wdest = '0; wdata = '0; raddr = '0; alloc_en = '0; alloc_preg = '0;
   endtask

   task automatic set_wr(input int k, input int d, input logic [WS-1:0] v);
      we[k] = 1'b1;
      wdest[k*AW +: AW] = AW'(d);
      wdata[k*WS +: WS] = v;
   endtask

   task automatic set_rd(input int r, input int a);
      raddr[r*AW +: AW] = AW'(a);
   endtask

   task automatic set_al(input int a, input int p);
      alloc_en[a] = 1'b1;
      alloc_preg[a*AW +: AW] = AW'(p);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WS-1:0] rd(input int r);
      return rdata[r*WS +: WS];
   endfunction

   function automatic int pick_reg();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11));
   endfunction

   initial begin
      rst = 1'b1;
      idle();
      #2;
      chk("reset_rdata0", rd(0), 32'h0);
      chk("reset_rready", {28'd0, rready}, 32'hF);
      chk("reset_conflict", {31'd0, wr_conflict}, 32'h0);
      step();
      rst = 1'b0;
      step();

      // Write then read: bypass same cycle, storage next cycle.
      idle(); set_wr(0, 3, 32'h1234); set_rd(0, 3); #1;
      chk("t2_bypass_data", rd(0), 32'h1234);
      chk("t2_bypass_ready", {31'd0, rready[0]}, 32'h1);
      step(); idle(); set_rd(0, 3); #1;
      chk("t2_rf_data", rd(0), 32'h1234);

      // Two ports to one register: higher port wins, one-cycle conflict pulse.
      idle(); set_wr(0, 7, 32'hAAAA); set_wr(1, 7, 32'h5555); set_rd(1, 7); #1;
      chk("t3_bypass_prio", rd(1), 32'h5555);
      chk("t3_conf_before", {31'd0, wr_conflict}, 32'h0);
      step(); idle(); set_rd(1, 7); #1;
      chk("t3_rf_prio", rd(1), 32'h5555);
      chk("t3_conf_pulse", {31'd0, wr_conflict}, 32'h1);
      step(); idle(); set_rd(1, 7); #1;
      chk("t3_conf_clear", {31'd0, wr_conflict}, 32'h0);

      // Alloc clears ready; a later write sets it again via bypass and storage.
      idle(); set_al(0, 9); step();
      idle(); set_rd(2, 9); #1;
      chk("t4_alloc_busy", {31'd0, rready[2]}, 32'h0);
      step(); idle(); set_wr(1, 9, 32'h42); set_rd(2, 9); #1;
      chk("t4_wb_ready", {31'd0, rready[2]}, 32'h1);
      chk("t4_wb_data", rd(2), 32'h42);
      step(); idle(); set_rd(2, 9); #1;
      chk("t4_stays_ready", {31'd0, rready[2]}, 32'h1);
      chk("t4_stays_data", rd(2), 32'h42);

      // Alloc and write to one register in one cycle: data lands, ready ends busy.
      idle(); set_al(1, 4); set_wr(0, 4, 32'h77); set_rd(3, 4); #1;
      chk("t5_same_cycle_ready", {31'd0, rready[3]}, 32'h1);
      step(); idle(); set_rd(3, 4); #1;
      chk("t5_data", rd(3), 32'h77);
      chk("t5_ready", {31'd0, rready[3]}, 32'h0);

      // p0 and out-of-range addresses are ignored and never conflict.
      idle(); set_wr(0, 0, 32'hFFFF); set_wr(1, 50, 32'hBEEF); set_rd(0, 0); set_rd(1, 50); #1;
      chk("t6_p0_data", rd(0), 32'h0);
      chk("t6_p0_ready", {31'd0, rready[0]}, 32'h1);
      chk("t6_oor_data", rd(1), 32'h0);
      step(); idle(); set_wr(0, 0, 32'h1); set_wr(1, 0, 32'h2); set_rd(1, 50); #1;
      chk("t6_oor_after", rd(1), 32'h0);
      step(); idle(); #1;
      chk("t6_p0_no_conflict", {31'd0, wr_conflict}, 32'h0);

      // Reset mid-write, with a conflict pending, clears everything at once.
      idle(); set_wr(0, 5, 32'h1111); set_wr(1, 5, 32'h2222); step();
      idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); #1;
      chk("t1_pre_bypass", rd(0), 32'hDEADBEEF);
      chk("t1_pre_conflict", {31'd0, wr_conflict}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("t1_rst_rdata", rd(0), 32'h0);
      chk("t1_rst_rready", {28'd0, rready}, 32'hF);
      chk("t1_rst_conflict", {31'd0, wr_conflict}, 32'h0);
      step();
      rst = 1'b0;
      idle(); set_rd(0, 5); #1;
      chk("t1_rf5_cleared", rd(0), 32'h0);
      step();

      // Random traffic checked every cycle by the compare process.
      for (int c = 0; c < 600; c++) begin
         idle();
         rst = ($urandom_range(0, 59) == 0);
         for (int k = 0; k < NW; k++)
            if ($urandom_range(0, 2) != 0) set_wr(k, pick_reg(), $urandom);
         for (int r = 0; r < NR; r++) set_rd(r, pick_reg());
         for (int a = 0; a < NA; a++)
            if ($urandom_range(0, 2) == 0) set_al(a, pick_reg());
         step();
      end
      rst = 1'b0;
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
